// File: rtl/vga_mode_ctrl.sv
// ---------------------------------------------------------------------------
// vga_mode_ctrl -- video-mode controller and frame sequencer.
//
// Holds a fixed four-entry table of display modes and presents the selected
// row as the VIS/FRONT/SYNC/BACK configuration for the horizontal and
// vertical sync-calc instances. Internal pixel/line counters generate the
// per-line V_STEP strobe and the FRAME_END strobe. Mode changes are only
// applied on a frame boundary. After reset and after every applied change,
// video stays muted for MUTE_FRAMES whole frames.
//
// Parameters:
//   MUTE_FRAMES  frames VIDEO_EN stays low after reset / mode switch (1..15)
//   RESET_MODE   mode index loaded on reset (0..3)
//
// Ports:
//   P_CLK        pixel clock
//   RST          synchronous active-low reset
//   MODE_REQ     mode-change request (sampled each cycle)
//   MODE_SEL     requested mode index, sampled with MODE_REQ
//   MODE_BUSY    change pending or mute in progress
//   MODE_ACK     one-cycle pulse when a requested change completes
//   CUR_MODE     mode currently applied
//   H_*/V_*      table row of CUR_MODE (visible, front porch, sync, back porch)
//   CALC_RST_N   active-low restart for both sync-calc instances
//   V_STEP       one-cycle pulse at the start of every line
//   FRAME_END    one-cycle pulse at the start of every frame
//   VIDEO_EN     high when video may be driven
//   FRAME_CNT    (only with VGA_FRAME_CNT_EN) frames since reset / last switch
//
// Optional feature macro: VGA_FRAME_CNT_EN adds the 16-bit FRAME_CNT output.
// ---------------------------------------------------------------------------
module vga_mode_ctrl #(
   parameter int unsigned MUTE_FRAMES = 2,
   parameter int unsigned RESET_MODE  = 0
) (
   input  logic        P_CLK,
   input  logic        RST,
   input  logic        MODE_REQ,
   input  logic [1:0]  MODE_SEL,
   output logic        MODE_BUSY,
   output logic        MODE_ACK,
   output logic [1:0]  CUR_MODE,
   output logic [11:0] H_VIS,
   output logic [11:0] V_VIS,
   output logic [7:0]  H_FRONT,
   output logic [7:0]  H_SYNC,
   output logic [7:0]  H_BACK,
   output logic [7:0]  V_FRONT,
   output logic [7:0]  V_SYNC,
   output logic [7:0]  V_BACK,
   output logic        CALC_RST_N,
   output logic        V_STEP,
   output logic        FRAME_END,
`ifdef VGA_FRAME_CNT_EN
   output logic [15:0] FRAME_CNT,
`endif
   output logic        VIDEO_EN
);

   localparam logic [1:0] ST_RUN  = 2'd0;
   localparam logic [1:0] ST_PEND = 2'd1;
   localparam logic [1:0] ST_MUTE = 2'd2;

   localparam logic [1:0] RST_MODE  = 2'(RESET_MODE);
   localparam logic [3:0] MUTE_INIT = 4'(MUTE_FRAMES);

   // Row layout: {h_vis, h_front, h_sync, h_back, v_vis, v_front, v_sync, v_back}
   function automatic logic [71:0] mode_row(input logic [1:0] m);
      logic [71:0] r;
      case (m)
         2'd0:    r = {12'd640,  8'd16, 8'd96,  8'd48,  12'd480,  8'd10, 8'd2, 8'd33};
         2'd1:    r = {12'd800,  8'd40, 8'd128, 8'd88,  12'd600,  8'd1,  8'd4, 8'd23};
         2'd2:    r = {12'd1024, 8'd24, 8'd136, 8'd160, 12'd768,  8'd3,  8'd6, 8'd29};
         default: r = {12'd1280, 8'd48, 8'd112, 8'd248, 12'd1024, 8'd1,  8'd3, 8'd38};
      endcase
      return r;
   endfunction

   logic [1:0]  state_q, state_d;
   logic [11:0] h_cnt_q, h_cnt_d;
   logic [11:0] v_cnt_q, v_cnt_d;
   logic [1:0]  cur_mode_q, cur_mode_d;
   logic [1:0]  pend_mode_q, pend_mode_d;
   logic [3:0]  mute_cnt_q, mute_cnt_d;
   logic        from_rst_q, from_rst_d;   // current mute was entered from reset
   logic        calc_rst_n_q, calc_rst_n_d;
   logic        v_step_q, v_step_d;
   logic        frame_end_q, frame_end_d;
   logic        ack_q, ack_d;
`ifdef VGA_FRAME_CNT_EN
   logic [15:0] frame_cnt_q, frame_cnt_d;
`endif

   logic [71:0] row;
   logic [11:0] ht, vt;
   logic        line_end, frame_bnd;

   // Table outputs follow cur_mode_q, which only moves at reset or at the
   // frame-boundary edge, so they never change mid-frame.
   assign row     = mode_row(cur_mode_q);
   assign H_VIS   = row[71:60];
   assign H_FRONT = row[59:52];
   assign H_SYNC  = row[51:44];
   assign H_BACK  = row[43:36];
   assign V_VIS   = row[35:24];
   assign V_FRONT = row[23:16];
   assign V_SYNC  = row[15:8];
   assign V_BACK  = row[7:0];

   // Totals fit in 12 bits (max 1688 / 1066).
   assign ht = H_VIS + {4'd0, H_FRONT} + {4'd0, H_SYNC} + {4'd0, H_BACK};
   assign vt = V_VIS + {4'd0, V_FRONT} + {4'd0, V_SYNC} + {4'd0, V_BACK};

   assign line_end  = (h_cnt_q == ht - 12'd1);
   assign frame_bnd = line_end && (v_cnt_q == vt - 12'd1);

   always_comb begin
      state_d      = state_q;
      cur_mode_d   = cur_mode_q;
      pend_mode_d  = pend_mode_q;
      mute_cnt_d   = mute_cnt_q;
      from_rst_d   = from_rst_q;
      calc_rst_n_d = 1'b1;
      v_step_d     = line_end;
      frame_end_d  = frame_bnd;
      ack_d        = 1'b0;

      if (line_end) begin
         h_cnt_d = 12'd0;
         v_cnt_d = frame_bnd ? 12'd0 : v_cnt_q + 12'd1;
      end else begin
         h_cnt_d = h_cnt_q + 12'd1;
         v_cnt_d = v_cnt_q;
      end

`ifdef VGA_FRAME_CNT_EN
      frame_cnt_d = frame_bnd ? frame_cnt_q + 16'd1 : frame_cnt_q;
`endif

      case (state_q)
         ST_RUN: begin
            if (MODE_REQ) begin
               pend_mode_d = MODE_SEL;
               state_d     = ST_PEND;
            end
         end
         ST_PEND: begin
            // Counters already wrap to 0 on this edge; only the mode and the
            // restart pulse need extra handling.
            if (frame_bnd) begin
               cur_mode_d   = pend_mode_q;
               calc_rst_n_d = 1'b0;
               mute_cnt_d   = MUTE_INIT;
               from_rst_d   = 1'b0;
               state_d      = ST_MUTE;
`ifdef VGA_FRAME_CNT_EN
               frame_cnt_d  = 16'd0;
`endif
            end
         end
         ST_MUTE: begin
            if (frame_bnd) begin
               if (mute_cnt_q == 4'd1) begin
                  state_d = ST_RUN;
                  ack_d   = ~from_rst_q;
               end else begin
                  mute_cnt_d = mute_cnt_q - 4'd1;
               end
            end
         end
         default: state_d = ST_MUTE;
      endcase
   end

   always_ff @(posedge P_CLK) begin
      if (!RST) begin
         state_q      <= ST_MUTE;
         h_cnt_q      <= 12'd0;
         v_cnt_q      <= 12'd0;
         cur_mode_q   <= RST_MODE;
         pend_mode_q  <= 2'd0;
         mute_cnt_q   <= MUTE_INIT;
         from_rst_q   <= 1'b1;
         calc_rst_n_q <= 1'b0;
         v_step_q     <= 1'b0;
         frame_end_q  <= 1'b0;
         ack_q        <= 1'b0;
`ifdef VGA_FRAME_CNT_EN
         frame_cnt_q  <= 16'd0;
`endif
      end else begin
         state_q      <= state_d;
         h_cnt_q      <= h_cnt_d;
         v_cnt_q      <= v_cnt_d;
         cur_mode_q   <= cur_mode_d;
         pend_mode_q  <= pend_mode_d;
         mute_cnt_q   <= mute_cnt_d;
         from_rst_q   <= from_rst_d;
         calc_rst_n_q <= calc_rst_n_d;
         v_step_q     <= v_step_d;
         frame_end_q  <= frame_end_d;
         ack_q        <= ack_d;
`ifdef VGA_FRAME_CNT_EN
         frame_cnt_q  <= frame_cnt_d;
`endif
      end
   end

   assign CUR_MODE   = cur_mode_q;
   assign CALC_RST_N = calc_rst_n_q;
   assign V_STEP     = v_step_q;
   assign FRAME_END  = frame_end_q;
   assign MODE_ACK   = ack_q;
   assign MODE_BUSY  = (state_q != ST_RUN);
   assign VIDEO_EN   = (state_q != ST_MUTE);
`ifdef VGA_FRAME_CNT_EN
   assign FRAME_CNT  = frame_cnt_q;
`endif

endmodule
